// File: rtl/sample_tick_sched_pkg.sv
// Purpose: shared constants and FSM encoding for the sample-tick scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sample_tick_sched_pkg;

    // Prescaler counter width; DIV_MAX must fit in this many bits.
    localparam int PRESCALE_W = 12;

    // Width of the saturating overrun event counter.
    localparam int OVR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Purpose: free-running prescaler producing a one-cycle sample-rate strobe.
// Latency: tick is registered, high the cycle after the count reaches DIV_MAX.
// Backpressure: none; enable low holds the count at 0 and suppresses tick.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - run enable; low clears and holds the prescaler
//   tick        - one-cycle strobe every DIV_MAX+1 enabled clocks
module sample_tick_gen
    import sample_tick_sched_pkg::*;
#(
    parameter int DIV_MAX = 2248
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(DIV_MAX);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == TERM);
            cnt  <= (cnt == TERM) ? '0 : cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/sample_tick_sched.sv
// Purpose: round-robin scheduler servicing requests latched on each sample tick.
// Latency: first grant 2 clocks after tick when idle; next grant 2 clocks after done.
// Backpressure: grant is held until the granted requester pulses done.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   enable         - prescaler run enable
//   req[NREQ]      - level requests, sampled only while tick is high
//   done[NREQ]     - completion pulse; only the granted bit is honoured
//   clear_overrun  - synchronous clear of overrun status
//   tick           - sample-rate strobe
//   grant[NREQ]    - one-hot grant, zero when nothing is being serviced
//   busy           - work pending or a grant cycle in progress
//   overrun        - sticky: a tick arrived while busy
//   overrun_cnt    - saturating count of overrun events
// Optional feature: define SAMPLE_TICK_SCHED_OVERRUN_EN to build overrun
// detection; otherwise overrun/overrun_cnt are constant 0.
module sample_tick_sched
    import sample_tick_sched_pkg::*;
#(
    parameter int DIV_MAX = 2248,
    parameter int NREQ    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      done,
    input  logic                 clear_overrun,
    output logic                 tick,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] overrun_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
    localparam logic [NREQ-1:0]  ONE      = NREQ'(1);

    sched_state_t     state, state_nxt;
    logic [NREQ-1:0]  pending, pending_nxt;
    logic [NREQ-1:0]  grant_nxt;
    logic [NREQ-1:0]  clr_mask;
    logic [IDX_W-1:0] last_grant, last_grant_nxt;
    logic [IDX_W-1:0] cur_idx, cur_idx_nxt;
    logic [IDX_W-1:0] idx_hi, idx_lo, sel_idx;
    logic             found_hi, found_lo, sel_found;
    logic             done_hit;

    sample_tick_gen #(
        .DIV_MAX (DIV_MAX)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Completion counts only on the bit currently granted.
    assign done_hit = (state == ST_WAIT) && (|(done & grant));
    assign clr_mask = done_hit ? grant : '0;

    // Clear happens before the tick merge so a same-cycle re-request survives.
    assign pending_nxt = (pending & ~clr_mask) | (tick ? req : '0);

    assign busy = (|pending) || (state != ST_IDLE);

    // Round-robin pick: lowest pending index above last_grant, else wrap to
    // the lowest pending index at or below it. Descending loops let the
    // lowest matching index win.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (pending[j] && (IDX_W'(j) > last_grant)) begin
                found_hi = 1'b1;
                idx_hi   = IDX_W'(j);
            end
            if (pending[j] && (IDX_W'(j) <= last_grant)) begin
                found_lo = 1'b1;
                idx_lo   = IDX_W'(j);
            end
        end
        sel_found = found_hi | found_lo;
        sel_idx   = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        cur_idx_nxt    = cur_idx;
        case (state)
            ST_IDLE: begin
                // Looking at the merged value saves a cycle after the tick.
                if (|pending_nxt) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_found) begin
                    grant_nxt   = ONE << sel_idx;
                    cur_idx_nxt = sel_idx;
                    state_nxt   = ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (done_hit) begin
                    grant_nxt      = '0;
                    last_grant_nxt = cur_idx;
                    state_nxt      = (|pending_nxt) ? ST_SELECT : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pending    <= '0;
            grant      <= '0;
            last_grant <= LAST_RST;
            cur_idx    <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            cur_idx    <= cur_idx_nxt;
        end
    end

`ifdef SAMPLE_TICK_SCHED_OVERRUN_EN
    logic ovr_event;

    // A new tick while the previous batch is still in flight.
    assign ovr_event = tick & busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (clear_overrun) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (ovr_event) begin
            overrun <= 1'b1;
            if (overrun_cnt != '1) begin
                overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
            end
        end
    end
`else
    logic unused_clear_overrun;

    assign unused_clear_overrun = clear_overrun;
    assign overrun              = 1'b0;
    assign overrun_cnt          = '0;
`endif

endmodule
